// File: rtl/des_cbc_block_framer.sv
// Byte-stream framer wrapped around a combinational DES decryption core.
// Collects eight ciphertext bytes into a block, holds it on the core input
// for a settle period, captures the result, optionally undoes CBC chaining,
// and offers the plaintext block on a valid/ready output.
module des_cbc_block_framer #(
    parameter int SETTLE_CYCLES = 4,
    parameter bit CBC           = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] iv,
    input  logic        iv_load,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [63:0] core_in,
    input  logic [63:0] core_out,
    output logic [63:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        busy,
    output logic [15:0] block_count
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SETTLE  = 2'd1,
        OUTPUT  = 2'd2
    } state_e;

    // Settle counter counts down to zero, so it is loaded one short of the hold time.
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_e      state_q;
    logic [2:0]  byteCnt_q;
    logic [7:0]  settleCnt_q;
    logic [63:0] coreIn_q;
    logic [63:0] chain_q;
    logic [63:0] mData_q;
    logic        mValid_q;
    logic [15:0] blockCount_q;
    logic [15:0] blockCount_d;

    logic        byteAccept;
    logic        outHandshake;
    logic        ivTake;
    logic [63:0] chainMask;

    assign s_ready      = (state_q == COLLECT);
    assign busy         = (state_q != COLLECT);
    assign byteAccept   = s_valid && s_ready;
    assign outHandshake = mValid_q && m_ready;

    // An IV may only replace the chain between blocks, never while a byte lands.
    assign ivTake       = iv_load && (state_q == COLLECT) && (byteCnt_q == 3'd0) && !byteAccept;

    // In ECB mode the chain register never contributes to the plaintext.
    assign chainMask    = CBC ? chain_q : 64'd0;

    assign blockCount_d = blockCount_q + {15'd0, outHandshake};

    assign core_in      = coreIn_q;
    assign m_data       = mData_q;
    assign m_valid      = mValid_q;
    assign block_count  = blockCount_q;

    // Main framer FSM: byte assembly, settle countdown, capture and output hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            byteCnt_q   <= 3'd0;
            settleCnt_q <= 8'd0;
            coreIn_q    <= 64'd0;
            chain_q     <= 64'd0;
            mData_q     <= 64'd0;
            mValid_q    <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (byteAccept) begin
                        coreIn_q <= {coreIn_q[55:0], s_data};
                        if (byteCnt_q == 3'd7) begin
                            byteCnt_q   <= 3'd0;
                            settleCnt_q <= SETTLE_LOAD;
                            state_q     <= SETTLE;
                        end else begin
                            byteCnt_q <= byteCnt_q + 3'd1;
                        end
                    end else if (ivTake && CBC) begin
                        chain_q <= iv;
                    end
                end
                SETTLE: begin
                    if (settleCnt_q == 8'd0) begin
                        mData_q  <= core_out ^ chainMask;
                        if (CBC) begin
                            chain_q <= coreIn_q;
                        end
                        mValid_q <= 1'b1;
                        state_q  <= OUTPUT;
                    end else begin
                        settleCnt_q <= settleCnt_q - 8'd1;
                    end
                end
                OUTPUT: begin
                    if (m_ready) begin
                        mValid_q <= 1'b0;
                        state_q  <= COLLECT;
                    end
                end
                default: begin
                    state_q <= COLLECT;
                end
            endcase
        end
    end

    // Completed-handshake counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blockCount_q <= 16'd0;
        end else begin
            blockCount_q <= blockCount_d;
        end
    end

endmodule

// File: tb/tb_des_cbc_block_framer.sv
// Testbench for des_cbc_block_framer: one CBC and one ECB instance share the
// byte stream; a stand-in core and a block-level plaintext model set the
// expected values.
module tb_des_cbc_block_framer;

    localparam int SETTLE = 4;
    localparam logic [63:0] KAT_CT = 64'h85E813540F0AB405;
    localparam logic [63:0] KAT_PT = 64'h0123456789ABCDEF;

    logic        clk;
    logic        rstN;
    logic [63:0] ivIn;
    logic        ivLoad;
    logic [7:0]  sData;
    logic        sValid;
    logic        mReady;

    logic        sReadyCbc, sReadyEcb;
    logic [63:0] coreInCbc, coreInEcb;
    logic [63:0] coreOutCbc, coreOutEcb;
    logic [63:0] mDataCbc, mDataEcb;
    logic        mValidCbc, mValidEcb;
    logic        busyCbc, busyEcb;
    logic [15:0] countCbc, countEcb;

    int          testsRun;
    int          testsFailed;
    logic [63:0] chainModel;
    logic [15:0] expCount;

    // Stand-in decryptor: one known DES answer, otherwise an arbitrary fixed mix.
    function automatic logic [63:0] coreModel(input logic [63:0] x);
        if (x == KAT_CT) return KAT_PT;
        return {x[22:0], x[63:23]} ^ (x * 64'h9E3779B97F4A7C15) ^ 64'h5555AAAA3333CCCC;
    endfunction

    assign coreOutCbc = coreModel(coreInCbc);
    assign coreOutEcb = coreModel(coreInEcb);

    des_cbc_block_framer #(.SETTLE_CYCLES(SETTLE), .CBC(1'b1)) dutCbc (
        .clk(clk), .rst_n(rstN), .iv(ivIn), .iv_load(ivLoad),
        .s_data(sData), .s_valid(sValid), .s_ready(sReadyCbc),
        .core_in(coreInCbc), .core_out(coreOutCbc),
        .m_data(mDataCbc), .m_valid(mValidCbc), .m_ready(mReady),
        .busy(busyCbc), .block_count(countCbc)
    );

    des_cbc_block_framer #(.SETTLE_CYCLES(SETTLE), .CBC(1'b0)) dutEcb (
        .clk(clk), .rst_n(rstN), .iv(ivIn), .iv_load(ivLoad),
        .s_data(sData), .s_valid(sValid), .s_ready(sReadyEcb),
        .core_in(coreInEcb), .core_out(coreOutEcb),
        .m_data(mDataEcb), .m_valid(mValidEcb), .m_ready(mReady),
        .busy(busyEcb), .block_count(countEcb)
    );

    // Free-running system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net against a stalled design.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Sends bytes first..last of a block (byte 0 is the most significant).
    task automatic applyStimulus(input logic [63:0] blk, input int first, input int last,
                                 input bit stall, input bit ivFirst);
        for (int i = first; i <= last; i++) begin
            int guard;
            guard = 0;
            if (stall) begin
                sValid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            sData  = blk[63 - 8*i -: 8];
            sValid = 1'b1;
            ivLoad = ivFirst && (i == first);
            while (!sReadyCbc && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            checkOutput("s_ready-wait", {63'd0, sReadyCbc}, 64'd1);
            @(negedge clk);
            sValid = 1'b0;
            ivLoad = 1'b0;
        end
    endtask

    task automatic waitOutput(input string tag, input bit ivPulse);
        int edges;
        edges = 0;
        if (ivPulse) ivIn = {$urandom, $urandom};
        ivLoad = ivPulse;
        while (!mValidCbc && edges < 40) begin
            @(negedge clk);
            ivLoad = 1'b0;
            edges++;
        end
        ivLoad = 1'b0;
        checkOutput({tag, "-latency"}, 64'(edges), 64'(SETTLE));
    endtask

    task automatic handshake(input string tag);
        mReady = 1'b1;
        @(negedge clk);
        mReady = 1'b0;
        expCount = expCount + 16'd1;
        checkOutput({tag, "-m_valid-drop"}, {62'd0, mValidCbc, mValidEcb}, 64'd0);
        checkOutput({tag, "-count-cbc"}, 64'(countCbc), 64'(expCount));
        checkOutput({tag, "-count-ecb"}, 64'(countEcb), 64'(expCount));
    endtask

    // Everything after the eighth byte has been accepted.
    task automatic finishBlock(input string tag, input logic [63:0] ct, input int readyDelay, input bit ivPulse);
        logic [63:0] expEcb;
        logic [63:0] expCbc;
        checkOutput({tag, "-core_in-cbc"}, coreInCbc, ct);
        checkOutput({tag, "-core_in-ecb"}, coreInEcb, ct);
        checkOutput({tag, "-busy"}, {62'd0, busyCbc, busyEcb}, 64'd3);
        waitOutput(tag, ivPulse);
        expEcb     = coreModel(ct);
        expCbc     = coreModel(ct) ^ chainModel;
        chainModel = ct;
        checkOutput({tag, "-data-ecb"}, mDataEcb, expEcb);
        checkOutput({tag, "-data-cbc"}, mDataCbc, expCbc);
        if (readyDelay > 0) begin
            repeat (readyDelay) @(negedge clk);
            checkOutput({tag, "-hold-cbc"}, mDataCbc, expCbc);
        end
        handshake(tag);
    endtask

    task automatic runBlock(input string tag, input logic [63:0] ct, input bit stall, input int readyDelay);
        applyStimulus(ct, 0, 7, stall, 1'b0);
        finishBlock(tag, ct, readyDelay, 1'b0);
    endtask

    task automatic loadIv(input logic [63:0] v);
        ivIn   = v;
        ivLoad = 1'b1;
        @(negedge clk);
        ivLoad     = 1'b0;
        chainModel = v;
    endtask

    // Directed sequence followed by a randomized run.
    initial begin
        logic [63:0] blkA;
        logic [63:0] blkB;
        logic [63:0] expA;

        testsRun    = 0;
        testsFailed = 0;
        chainModel  = 64'd0;
        expCount    = 16'd0;
        rstN   = 1'b0;
        ivIn   = 64'd0;
        ivLoad = 1'b0;
        sData  = 8'd0;
        sValid = 1'b0;
        mReady = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst-core_in", coreInCbc | coreInEcb, 64'd0);
        checkOutput("rst-m_data", mDataCbc | mDataEcb, 64'd0);
        checkOutput("rst-m_valid", {62'd0, mValidCbc, mValidEcb}, 64'd0);
        checkOutput("rst-count", {32'd0, countCbc, countEcb}, 64'd0);
        checkOutput("rst-s_ready", {62'd0, sReadyCbc, sReadyEcb}, 64'd3);
        checkOutput("rst-busy", {62'd0, busyCbc, busyEcb}, 64'd0);
        rstN = 1'b1;
        @(negedge clk);

        // Known answer, chain zero after reset.
        runBlock("kat-plain", KAT_CT, 1'b0, 0);
        checkOutput("kat-ecb-const", mDataEcb, KAT_PT);

        // IV of 1, then plain chaining on the same ciphertext.
        loadIv(64'h0000000000000001);
        runBlock("kat-iv", KAT_CT, 1'b0, 0);
        checkOutput("kat-iv-const", mDataCbc, 64'h0123456789ABCDEE);
        runBlock("kat-chain", KAT_CT, 1'b0, 0);
        checkOutput("kat-chain-const", mDataCbc, 64'h84CB563386A179EA);

        // Backpressure with a byte waiting upstream.
        blkA = {$urandom, $urandom};
        blkB = {$urandom, $urandom};
        applyStimulus(blkA, 0, 7, 1'b0, 1'b0);
        checkOutput("bp-core_in", coreInCbc, blkA);
        waitOutput("bp", 1'b0);
        expA       = coreModel(blkA) ^ chainModel;
        chainModel = blkA;
        sData  = blkB[63:56];
        sValid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp-s_ready", {62'd0, sReadyCbc, sReadyEcb}, 64'd0);
            checkOutput("bp-hold", mDataCbc, expA);
            checkOutput("bp-no-consume", coreInCbc, blkA);
        end
        handshake("bp");
        checkOutput("bp-no-accept-on-handshake", coreInCbc, blkA);
        checkOutput("bp-resume-ready", {63'd0, sReadyCbc}, 64'd1);
        @(negedge clk);
        sValid = 1'b0;
        checkOutput("bp-resume-accept", coreInCbc, {blkA[55:0], blkB[63:56]});
        applyStimulus(blkB, 1, 7, 1'b0, 1'b0);
        finishBlock("bp-next", blkB, 0, 1'b0);

        // IV loads that must be ignored: with a byte accept, mid-block, in SETTLE.
        blkA = {$urandom, $urandom};
        ivIn = {$urandom, $urandom};
        applyStimulus(blkA, 0, 2, 1'b0, 1'b1);
        ivLoad = 1'b1;
        @(negedge clk);
        ivLoad = 1'b0;
        applyStimulus(blkA, 3, 7, 1'b0, 1'b0);
        finishBlock("iv-ignored", blkA, 0, 1'b1);
        runBlock("iv-ignored-next", {$urandom, $urandom}, 1'b0, 0);

        // Reset in the middle of a block clears chain, count and partial bytes.
        applyStimulus({$urandom, $urandom}, 0, 4, 1'b0, 1'b0);
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("midrst-core_in", coreInCbc, 64'd0);
        checkOutput("midrst-count", 64'(countCbc), 64'd0);
        rstN       = 1'b1;
        chainModel = 64'd0;
        expCount   = 16'd0;
        @(negedge clk);
        runBlock("post-reset", {$urandom, $urandom}, 1'b0, 0);

        // Counter wrap via a one-edge back-door on the next-count value.
        force dutCbc.blockCount_d = 16'hFFFF;
        force dutEcb.blockCount_d = 16'hFFFF;
        @(negedge clk);
        release dutCbc.blockCount_d;
        release dutEcb.blockCount_d;
        expCount = 16'hFFFF;
        checkOutput("wrap-preset", 64'(countCbc), 64'hFFFF);
        runBlock("wrap", {$urandom, $urandom}, 1'b0, 0);
        checkOutput("wrap-zero", {32'd0, countCbc, countEcb}, 64'd0);

        // Randomized blocks with stalls, output backpressure and fresh IVs.
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0) loadIv({$urandom, $urandom});
            runBlock("rand", {$urandom, $urandom}, 1'b1, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/des_cbc_block_framer.md
Name: des_cbc_block_framer

Overview:
- Front/back stage wrapped around the combinational DES decryption core.
- Assembles a byte stream of ciphertext into 64-bit blocks and drives them onto the core's data input.
- Holds the block stable for a fixed settle time, then captures the core result. In CBC mode it XORs the result with the previous ciphertext block (or the IV).
- Presents each recovered 64-bit plaintext block on a valid/ready output.

Parameters:
- SETTLE_CYCLES, 4, clock cycles the core input is held stable before the result is captured. Legal range 1..255.
- CBC, 1, 1 = CBC unchaining; 0 = ECB pass-through (no XOR, chain register unused).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- iv  in  64  initialisation vector.
- iv_load  in  1  load iv into the chain register.
- s_data  in  8  ciphertext byte.
- s_valid  in  1  s_data valid.
- s_ready  out  1  byte accepted when s_valid && s_ready.
- core_in  out  64  block to the decryptor data input. Bit 63 is DES bit 1.
- core_out  in  64  decryptor result. Bit 63 is DES bit 1.
- m_data  out  64  recovered plaintext block.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts m_data when m_valid && m_ready.
- busy  out  1  high in SETTLE or OUTPUT.
- block_count  out  16  number of completed output handshakes.

Behaviour:
- Reset (asynchronous, rst_n=0), all registers cleared:
  - state=COLLECT, byte_cnt=0, settle_cnt=0.
  - core_in=0, chain=0, m_data=0, m_valid=0, block_count=0.
  - s_ready and busy follow from state.
- Reset mid-block discards partial bytes, any pending output and the chain value.
- FSM states: COLLECT, SETTLE, OUTPUT.
- COLLECT:
  - s_ready=1.
  - On each accepted byte: core_in <= {core_in[55:0], s_data}, so the first byte lands in [63:56] after 8 bytes; byte_cnt+1.
  - On the 8th accepted byte: byte_cnt<=0, settle_cnt<=SETTLE_CYCLES-1, state->SETTLE.
- SETTLE:
  - s_ready=0; core_in is frozen.
  - Each edge: if settle_cnt==0, capture and go to OUTPUT; else settle_cnt-1.
  - Capture action:
    - m_data <= core_out ^ (CBC ? chain : 0).
    - chain <= core_in, i.e. the current ciphertext.
    - m_valid <= 1, state->OUTPUT.
  - The capture edge is exactly SETTLE_CYCLES edges after the edge that accepted the 8th byte.
- OUTPUT:
  - s_ready=0; m_valid=1; m_data is stable until the handshake.
  - On m_valid && m_ready: m_valid<=0, block_count<=block_count+1 (wraps 0xFFFF->0x0000), state->COLLECT.
  - The first new byte is accepted no earlier than the cycle after the handshake.
- busy = (state != COLLECT).
- iv_load:
  - Takes effect only when state==COLLECT && byte_cnt==0 && no byte is accepted that cycle. chain <= iv.
  - Ignored in all other cases: mid-block, SETTLE, OUTPUT, or simultaneous with a byte accept.
- The chain register updates only at capture, and only when CBC=1. With CBC=0, m_data = core_out exactly.
- The key is not handled here; the core's key input is wired at top level and must be stable before the first block.
- s_valid deasserting mid-block simply stalls COLLECT. No timeout.

Test Plan:
- Core = decryptor with key 133457799BBCDFF1, CBC=0. Stream bytes 85 E8 13 54 0F 0A B4 05 -> core_in=85E813540F0AB405; m_valid rises exactly SETTLE_CYCLES edges after the 8th accept; m_data=0123456789ABCDEF; block_count=1.
- CBC=1, iv_load with iv=0000000000000001, then same block -> m_data=0123456789ABCDEE. Same block again -> m_data=84CB563386A179EA (previous ciphertext XOR).
- Hold m_ready=0 for 10 cycles while s_valid=1 -> s_ready=0, m_data stable, no bytes consumed. Raise m_ready -> one handshake, then byte acceptance resumes the next cycle.
- Assert iv_load after 3 bytes, and again during SETTLE -> chain unchanged; the output matches the no-load expectation.
- Drop rst_n after 5 bytes, release, then send a full block -> output is that block decrypted XOR 0 (chain cleared); block_count=1.
- Force block_count to 0xFFFF via 65535 blocks (or a bench back-door) -> the next handshake reads 0x0000.
